// File: rtl/canny_pkg.sv
// Types and neighbour-index constants shared by the Canny window generator
// and the hysteresis stage that consumes its taps.
package canny_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;

    localparam logic [3:0] CENTRE = 4'd0;
    localparam logic [3:0] NW     = 4'd1;
    localparam logic [3:0] N      = 4'd2;
    localparam logic [3:0] NE     = 4'd3;
    localparam logic [3:0] W      = 4'd4;
    localparam logic [3:0] E      = 4'd5;
    localparam logic [3:0] SW     = 4'd6;
    localparam logic [3:0] S      = 4'd7;
    localparam logic [3:0] SE     = 4'd8;

    localparam int NUM_TAPS = 9;

    // A pixel at (r,c) completes a full window once two rows and two columns precede it.
    function automatic logic completes_window(input coord_t r, input coord_t c);
        return (r >= 10'd2) && (c >= 10'd2);
    endfunction

endpackage

// File: rtl/hysteresis_window_if.sv
// Pixel stream in, 3x3 neighbourhood taps and position out.
interface hysteresis_window_if;

    canny_pkg::pixel_t pixel_in;
    logic              pixel_valid;
    logic              frame_start;
    canny_pkg::pixel_t win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic              window_valid;
    canny_pkg::coord_t center_row;
    canny_pkg::coord_t center_col;
    logic              frame_done;

    modport master (
        output pixel_in, pixel_valid, frame_start,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  window_valid, center_row, center_col, frame_done
    );

    modport slave (
        input  pixel_in, pixel_valid, frame_start,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output window_valid, center_row, center_col, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: asynchronous read of the old value at addr,
// synchronous write of the new value to the same location.
module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        din,
    output pixel_t        dout
);

    pixel_t mem_r [DEPTH];

    assign dout = mem_r[addr];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

endmodule

// File: rtl/hysteresis_window.sv
// Streaming 3x3 neighbourhood generator feeding the hysteresis stage:
// two line buffers, a 3x3 tap register array and raster position tracking.
module hysteresis_window
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                clk,
    input  logic                rst,
    hysteresis_window_if.slave  bus
);

    localparam int     AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam coord_t LAST_COL = coord_t'(IMG_WIDTH - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_HEIGHT - 1);

    coord_t row_r, col_r;
    coord_t pos_row_s, pos_col_s;
    coord_t next_row_s, next_col_s;
    pixel_t top_s, mid_s;
    pixel_t win_r [NUM_TAPS];
    logic   valid_r, done_r;
    coord_t crow_r, ccol_r;
    logic   accept_s;

    assign accept_s = bus.pixel_valid;

    // Position of the pixel being accepted (frame_start forces the origin) and the counter successor.
    always_comb begin
        pos_row_s  = row_r;
        pos_col_s  = col_r;
        next_row_s = row_r;
        next_col_s = col_r;
        if (bus.frame_start) begin
            pos_row_s = 10'd0;
            pos_col_s = 10'd0;
        end else begin
            pos_row_s = row_r;
            pos_col_s = col_r;
        end
        if (pos_col_s == LAST_COL) begin
            next_col_s = 10'd0;
            if (pos_row_s == LAST_ROW) begin
                next_row_s = 10'd0;
            end else begin
                next_row_s = pos_row_s + 10'd1;
            end
        end else begin
            next_col_s = pos_col_s + 10'd1;
            next_row_s = pos_row_s;
        end
    end

    // lb1 holds the previous line, lb2 the line before it; lb1's old value cascades into lb2.
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb1 (
        .clk  (clk),
        .we   (accept_s),
        .addr (pos_col_s[AW-1:0]),
        .din  (bus.pixel_in),
        .dout (mid_s)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb2 (
        .clk  (clk),
        .we   (accept_s),
        .addr (pos_col_s[AW-1:0]),
        .din  (mid_s),
        .dout (top_s)
    );

    // Counters, tap shift register and the registered valid/position/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r   <= 10'd0;
            col_r   <= 10'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            crow_r  <= 10'd0;
            ccol_r  <= 10'd0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                win_r[i] <= 8'd0;
            end
        end else if (accept_s) begin
            row_r      <= next_row_s;
            col_r      <= next_col_s;
            // Each tap row slides one column west; the new east column comes from the line buffers.
            win_r[NW]     <= win_r[N];
            win_r[N]      <= win_r[NE];
            win_r[NE]     <= top_s;
            win_r[W]      <= win_r[CENTRE];
            win_r[CENTRE] <= win_r[E];
            win_r[E]      <= mid_s;
            win_r[SW]     <= win_r[S];
            win_r[S]      <= win_r[SE];
            win_r[SE]     <= bus.pixel_in;
            valid_r    <= completes_window(pos_row_s, pos_col_s);
            done_r     <= (pos_row_s == LAST_ROW) && (pos_col_s == LAST_COL);
            if (completes_window(pos_row_s, pos_col_s)) begin
                crow_r <= pos_row_s - 10'd1;
                ccol_r <= pos_col_s - 10'd1;
            end
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end
    end

    assign bus.win0         = win_r[CENTRE];
    assign bus.win1         = win_r[NW];
    assign bus.win2         = win_r[N];
    assign bus.win3         = win_r[NE];
    assign bus.win4         = win_r[W];
    assign bus.win5         = win_r[E];
    assign bus.win6         = win_r[SW];
    assign bus.win7         = win_r[S];
    assign bus.win8         = win_r[SE];
    assign bus.window_valid = valid_r;
    assign bus.frame_done   = done_r;
    assign bus.center_row   = crow_r;
    assign bus.center_col   = ccol_r;

endmodule

// File: tb/tb_hysteresis_window.sv
// Scoreboard bench for hysteresis_window on a 4x4 image: expected windows are
// built from a bench-side image copy when pixels are driven, compared on output.
module tb_hysteresis_window;
    import canny_pkg::*;

    localparam int IW = 4;
    localparam int IH = 4;

    typedef struct packed {
        logic [71:0] win;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hysteresis_window_if bus();

    hysteresis_window #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    pixel_t      img [IH][IW];
    int          mr = 0;
    int          mc = 0;
    int          win_count = 0;
    int          done_count = 0;
    int          capture_idx = 0;
    logic [71:0] fw = 72'd0;
    logic [19:0] fpos = 20'd0;
    logic        acc_prev = 1'b0;
    logic [91:0] snap = 92'd0;

    function automatic logic [71:0] obs_win();
        return {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                bus.win5, bus.win6, bus.win7, bus.win8};
    endfunction

    function automatic logic [91:0] obs_all();
        return {obs_win(), bus.center_row, bus.center_col};
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_px(input pixel_t v, input logic fs);
        int   r, c;
        exp_t e;
        @(posedge clk); #1;
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = v;
        bus.frame_start = fs;
        if (fs) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        img[r][c] = v;
        if (r >= 2 && c >= 2) begin
            e.win  = {img[r-1][c-1], img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                      img[r-1][c-2], img[r-1][c], img[r][c-2], img[r][c-1], img[r][c]};
            e.row  = 10'(r - 1);
            e.col  = 10'(c - 1);
            e.done = (r == IH - 1) && (c == IW - 1);
            sb.push_back(e);
        end
        if (c == IW - 1) begin
            mc = 0;
            mr = (r == IH - 1) ? 0 : r + 1;
        end else begin
            mc = c + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.pixel_valid = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    task automatic drive_frame(input pixel_t base, input int gap, input logic fs);
        for (int i = 0; i < IW * IH; i++) begin
            drive_px(base + pixel_t'(16 * (i / IW) + (i % IW)), fs && (i == 0));
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic begin_scn(input int cap);
        win_count   = 0;
        done_count  = 0;
        capture_idx = cap;
        fw          = 72'd0;
        fpos        = 20'd0;
    endtask

    task automatic end_scn(input string tag, input int wins, input int dones, input logic [71:0] first);
        idle(4);
        check({tag, "_windows"}, 96'(win_count), 96'(wins));
        check({tag, "_frame_done"}, 96'(done_count), 96'(dones));
        check({tag, "_first_win"}, 96'(fw), 96'(first));
        check({tag, "_first_pos"}, 96'(fpos), 96'({10'd1, 10'd1}));
        check({tag, "_sb_empty"}, 96'(sb.size()), 96'd0);
    endtask

    always @(posedge clk) acc_prev = bus.pixel_valid;

    // Output monitor: pops the scoreboard on every valid window, otherwise checks quiet/hold behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.window_valid) begin
                check("sb_pending", 96'(sb.size() != 0), 96'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("win", 96'(obs_win()), 96'(mon_e.win));
                    check("center_row", 96'(bus.center_row), 96'(mon_e.row));
                    check("center_col", 96'(bus.center_col), 96'(mon_e.col));
                    check("frame_done", 96'(bus.frame_done), 96'(mon_e.done));
                end
                if (win_count == capture_idx) begin
                    fw   = obs_win();
                    fpos = {bus.center_row, bus.center_col};
                end
                win_count++;
                if (bus.frame_done) done_count++;
            end else begin
                check("done_without_valid", 96'(bus.frame_done), 96'd0);
                if (!acc_prev) check("hold", 96'(obs_all()), 96'(snap));
            end
        end
        snap = obs_all();
    end

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = 8'd0;
        bus.frame_start = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset_state", 96'({obs_all(), bus.window_valid, bus.frame_done}), 96'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Continuous frame.
        begin_scn(0);
        drive_frame(8'h00, 0, 1'b1);
        end_scn("continuous", 4, 1, 72'h11_00_01_02_10_12_20_21_22);

        // Three bubble cycles after every pixel.
        begin_scn(0);
        drive_frame(8'h00, 3, 1'b1);
        end_scn("bubbles", 4, 1, 72'h11_00_01_02_10_12_20_21_22);

        // Six pixels of a stale frame, then a resynchronising frame.
        begin_scn(0);
        for (int i = 0; i < 6; i++) drive_px(pixel_t'(16 * (i / IW) + (i % IW)) + 8'h40, 1'b0);
        drive_frame(8'h00, 0, 1'b1);
        end_scn("resync", 4, 1, 72'h11_00_01_02_10_12_20_21_22);

        // Reset after pixel 0x21, then a fresh frame without frame_start.
        begin_scn(0);
        for (int i = 0; i < 10; i++) drive_px(pixel_t'(16 * (i / IW) + (i % IW)), i == 0);
        @(posedge clk); #1;
        bus.pixel_valid = 1'b0;
        rst = 1'b1;
        #1 check("mid_reset_outputs", 96'({obs_all(), bus.window_valid, bus.frame_done}), 96'd0);
        idle(3);
        check("reset_valid_low", 96'(bus.window_valid), 96'd0);
        rst = 1'b0;
        mr = 0;
        mc = 0;
        sb.delete();
        drive_frame(8'h00, 0, 1'b0);
        end_scn("reset", 4, 1, 72'h11_00_01_02_10_12_20_21_22);

        // Two frames back to back; capture the second frame's first window.
        begin_scn(4);
        drive_frame(8'h00, 0, 1'b1);
        drive_frame(8'h80, 0, 1'b0);
        end_scn("b2b", 8, 2, 72'h91_80_81_82_90_92_a0_a1_a2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hysteresis_window.md
# hysteresis_window

Streaming 3x3 neighbourhood generator that sits directly upstream of the `hysteresis` stage in the Canny pipeline. It accepts non-maximum-suppressed gradient magnitudes in raster order, one 8-bit pixel per accepted cycle. It buffers two image lines and presents, for every interior pixel, the centre value plus its eight neighbours on `input0`..`input8`-compatible outputs. It also drives a qualifying strobe that feeds `hysteresis_enable`.

## Interface
Parameters:
- IMG_WIDTH, 64, pixels per line; legal range 3..1024.
- IMG_HEIGHT, 64, lines per frame; legal range 3..1024.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- pixel_in  in  8  magnitude sample, raster order.
- pixel_valid  in  1  pixel_in is accepted on this edge. No backpressure.
- frame_start  in  1  when high together with pixel_valid, the accepted pixel is (row 0, col 0).
- win0..win8  out  8 each  window. win0 is the centre. The neighbours are win1=NW, win2=N, win3=NE, win4=W, win5=E, win6=SW, win7=S, win8=SE.
- window_valid  out  1  win0..win8 hold a complete interior window; connects to hysteresis_enable.
- center_row  out  10  row of win0.
- center_col  out  10  column of win0.
- frame_done  out  1  one-cycle pulse coincident with the last window of the frame.

## Operation
- Counters `row`, `col` give the position of the next pixel to accept.
  - An accept increments `col`.
  - At col = IMG_WIDTH-1 the accept wraps `col` to 0 and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) the accept wraps both counters to 0.
- frame_start on an accept forces the pixel's position to (0,0), so the counters become (0,1). This resynchronises mid-frame. Partially buffered lines are simply overwritten.
- Line buffers lb1 and lb2 are IMG_WIDTH x 8 each, addressed by `col`. On every accept, in a single edge:
  - top = lb2[col], mid = lb1[col], bot = pixel_in.
  - lb2[col] <= lb1[col] and lb1[col] <= pixel_in.
- The window register array is 3x3. On an accept, each row shifts left one column. The new right column is {top, mid, bot}.
- Validity: on an accept of pixel (r,c) with r >= 2 and c >= 2, window_valid is set on the next cycle. The window is then centred at (r-1, c-1), and center_row/center_col are r-1 and c-1.
  - Border pixels (row or col 0 or max) never produce a window.
  - The window holds stale columns after a line wrap. These are never flagged valid.
- No accept on a cycle: window_valid goes low and the window, center_* and line buffers hold.
- frame_done is set together with window_valid for the window created by accepting (IMG_HEIGHT-1, IMG_WIDTH-1).
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Reset value of every output, counter and window register is 0. Line buffer contents are don't-care and need not be reset.
- Reset mid-frame: the next accepted pixel is treated as (0,0) regardless of frame_start.

## Timing
- Latency: 1 cycle from the accepting edge of the completing pixel to valid outputs.
- Throughput: one window per clock at 100% pixel_valid duty.
- All outputs are registered. There is no combinational path from inputs to outputs.
- window_valid and frame_done are single-cycle pulses per accept. Back-to-back accepts give back-to-back valid windows.
- frame_start with pixel_valid low has no effect.

## Structure
- Shared package `canny_pkg`:
  - pixel_t (8-bit).
  - coord_t (10-bit).
  - localparam neighbour index constants (CENTRE=0 .. SE=8), shared with the hysteresis stage.
- One sub-module, `line_buffer`:
  - Parameter DEPTH.
  - Ports: clk, we, addr, din, dout.
  - Asynchronous read of the old value and synchronous write in the same cycle.
  - Instantiated twice.
- Top level holds the counters, the 3x3 register array and the valid/position logic.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel (r,c) = 16*r+c.
- Continuous frame: the cycle after pixel 0x22 is accepted, window_valid=1, win0=0x11, win1..win8 = 00,01,02,10,12,20,21,22, center=(1,1). Exactly 4 valid windows follow, with centres (1,1),(1,2),(2,1),(2,2). frame_done is 1 only with the (2,2) window: win0=0x22, win8=0x33.
- Bubbles: insert pixel_valid=0 for 3 cycles between every pixel. Window values and order are identical to the continuous case. window_valid is never high during bubbles, and outputs hold.
- Resync: stream 6 pixels, then assert frame_start with a full frame. The first window appears after the new frame's 11th accept and has the correct values. There is no spurious valid during the first two rows.
- Reset mid-frame: assert rst after pixel 0x21. All outputs are 0 at once and window_valid stays low. A fresh frame then gives the correct 4 windows.
- Back-to-back frames: two frames with no gap, the second using values 0x80+16*r+c. frame_done pulses exactly twice. The second frame's first window has win0=0x91 and win1=0x80.
